// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg: shared line-state and controller-state types for the USB RX timing path.
package usb_rx_pkg;
    typedef enum logic [1:0] {LS_J, LS_K, LS_SE0, LS_SE1} line_state_t;
    typedef enum logic [1:0] {IDLE, ACTIVE, EOP_SE0} rx_ctrl_state_t;

    function automatic line_state_t decode_line(input logic dp, input logic dm);
        return (dp && !dm) ? LS_J : (!dp && dm) ? LS_K : dp ? LS_SE1 : LS_SE0;
    endfunction
endpackage

// File: rtl/usb_line_state_reg.sv
// usb_line_state_reg: registers the decoded bus state twice and flags J/K data edges and J->K SOP.
module usb_line_state_reg import usb_rx_pkg::*; (
    input  logic        clk,
    input  logic        rst,
    input  logic        dp_sync,
    input  logic        dm_sync,
    output line_state_t cur,
    output logic        je_edge,
    output logic        sop_edge
);
    line_state_t cur_q, cur_d, prv_q;

    always_comb cur_d = decode_line(dp_sync, dm_sync);

    // Both stages reset to SE0 so an explicit J is needed before any SOP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_q <= LS_SE0;
            prv_q <= LS_SE0;
        end else begin
            cur_q <= cur_d;
            prv_q <= cur_q;
        end
    end

    assign cur      = cur_q;
    assign sop_edge = (prv_q == LS_J) && (cur_q == LS_K);
    assign je_edge  = sop_edge || ((prv_q == LS_K) && (cur_q == LS_J));
endmodule

// File: rtl/usb_rx_timing_ctrl.sv
// usb_rx_timing_ctrl: SOP/EOP sequencing, phase-drift readjust and abort detection
// controlling the RX bit-timing divider.
module usb_rx_timing_ctrl import usb_rx_pkg::*; #(
    parameter int CLKS_PER_BIT = 8,
    parameter int EOP_SE0_BITS = 2,
    parameter int MAX_RUN_BITS = 7,
    parameter int PH_TOL       = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic dp_sync,
    input  logic dm_sync,
    input  logic bit_strobe,
    output logic en_clk_div,
    output logic counter_clear,
    output logic readjust,
    output logic rx_active,
    output logic eop,
    output logic rx_error
);
    localparam int PHW  = $clog2(CLKS_PER_BIT);
    localparam int RUNW = $clog2(MAX_RUN_BITS + 1);
    localparam int SE0W = $clog2(EOP_SE0_BITS + 3);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam logic [PHW-1:0]  PH_MAX  = PHW'(CLKS_PER_BIT - 1);
    localparam logic [RUNW-1:0] RUN_LST = RUNW'(MAX_RUN_BITS - 1);
    localparam logic [SE0W-1:0] SE0_MIN = SE0W'(EOP_SE0_BITS);
    localparam logic [SE0W-1:0] SE0_MAX = SE0W'(EOP_SE0_BITS + 1);

    line_state_t    cur;
    logic           je_edge, sop_edge, ph_far;
    rx_ctrl_state_t state_q, state_d;
    logic [PHW-1:0]  ph_q, ph_d;
    logic [RUNW-1:0] run_q, run_d;
    logic [SE0W-1:0] se0_q, se0_d;
    logic act_q, act_d, clr_q, clr_d, radj_q, radj_d, eop_q, eop_d, err_q, err_d;

    usb_line_state_reg u_line (
        .clk      (clk),
        .rst      (rst),
        .dp_sync  (dp_sync),
        .dm_sync  (dm_sync),
        .cur      (cur),
        .je_edge  (je_edge),
        .sop_edge (sop_edge)
    );

    assign ph_far = (int'(ph_q) > HALF + PH_TOL) || (int'(ph_q) < HALF - PH_TOL);

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        run_d   = run_q;
        se0_d   = se0_q;
        clr_d   = 1'b0;
        radj_d  = 1'b0;
        eop_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (sop_edge) begin
                    state_d = ACTIVE;
                    clr_d   = 1'b1;
                    ph_d    = '0;
                    run_d   = '0;
                end
            end
            ACTIVE: begin
                ph_d = bit_strobe ? '0 : (ph_q == PH_MAX) ? ph_q : ph_q + PHW'(1);
                if (cur == LS_SE1) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (cur == LS_SE0) begin
                    state_d = EOP_SE0;
                    se0_d   = '0;
                end else if (je_edge) begin
                    // An edge wins over a coincident strobe: the run restarts.
                    run_d = '0;
                    if (ph_far) begin
                        radj_d = 1'b1;
                        clr_d  = 1'b1;
                        ph_d   = '0;
                    end
                end else if (bit_strobe) begin
                    run_d = run_q + RUNW'(1);
                    if (run_q == RUN_LST) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            EOP_SE0: begin
                if (cur == LS_SE1 || cur == LS_K) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (cur == LS_J) begin
                    eop_d   = se0_q >= SE0_MIN;
                    err_d   = se0_q < SE0_MIN;
                    state_d = IDLE;
                end else if (se0_q > SE0_MAX) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (bit_strobe) begin
                    se0_d = se0_q + SE0W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        act_d = state_d != IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ph_q    <= '0;
            run_q   <= '0;
            se0_q   <= '0;
            act_q   <= 1'b0;
            clr_q   <= 1'b0;
            radj_q  <= 1'b0;
            eop_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            run_q   <= run_d;
            se0_q   <= se0_d;
            act_q   <= act_d;
            clr_q   <= clr_d;
            radj_q  <= radj_d;
            eop_q   <= eop_d;
            err_q   <= err_d;
        end
    end

    assign en_clk_div    = act_q;
    assign rx_active     = act_q;
    assign counter_clear = clr_q;
    assign readjust      = radj_q;
    assign eop           = eop_q;
    assign rx_error      = err_q;
endmodule

// File: tb/tb_usb_rx_timing_ctrl.sv
// tb_usb_rx_timing_ctrl: random packets built at bit level, expected pulses queued per packet
// and matched by an independent negedge monitor.
module tb_usb_rx_timing_ctrl;
    localparam logic [1:0] LJ = 2'b10, LK = 2'b01, LSE0 = 2'b00, LSE1 = 2'b11;
    localparam logic [5:0] V_SOP = 6'b111000, V_RA = 6'b111100, V_EOP = 6'b000010, V_ERR = 6'b000001;

    logic clk = 1'b0, rst = 1'b1, dp_sync = 1'b0, dm_sync = 1'b0, bit_strobe = 1'b0;
    logic en_clk_div, counter_clear, readjust, rx_active, eop, rx_error;

    usb_rx_timing_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .dp_sync       (dp_sync),
        .dm_sync       (dm_sync),
        .bit_strobe    (bit_strobe),
        .en_clk_div    (en_clk_div),
        .counter_clear (counter_clear),
        .readjust      (readjust),
        .rx_active     (rx_active),
        .eop           (eop),
        .rx_error      (rx_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [5:0] v;
        string      name;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        pend[$];
    logic [1:0] ln_q[$];
    bit         st_q[$];
    int         g0;
    int         n_cmp = 0, n_bad = 0;

    wire [5:0] obs = {en_clk_div, rx_active, counter_clear, readjust, eop, rx_error};

    task automatic check(input string name, input logic [5:0] got, input logic [5:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: outputs %b, required %b", name, cyc, got, want);
        end
    endtask

    // Monitor: matches every visible pulse or enable change against the expected queue.
    initial begin
        logic en_prev;
        ev_t  e;
        en_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    e = exp_q.pop_front();
                    n_cmp++;
                    n_bad++;
                    $display("FAIL missing %s at cycle %0d: outputs never showed %b", e.name, e.cyc, e.v);
                end
                if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                    e = exp_q.pop_front();
                    check(e.name, obs, e.v);
                end else if (counter_clear || readjust || eop || rx_error ||
                             en_clk_div !== en_prev || rx_active !== en_clk_div) begin
                    check("unexpected", obs, {en_prev, en_prev, 4'b0000});
                end
            end
            en_prev = en_clk_div;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic add(input logic [1:0] l, input bit s);
        ln_q.push_back(l);
        st_q.push_back(s);
    endtask

    // Strobes run every CLKS_PER_BIT clocks starting one bit after the SOP decision.
    task automatic add_auto(input logic [1:0] l);
        int idx;
        idx = ln_q.size();
        add(l, idx > g0 && (idx - g0) % 8 == 0);
    endtask

    task automatic expect_ev(input int rel, input logic [5:0] v, input string n);
        ev_t e;
        e.cyc  = rel;
        e.v    = v;
        e.name = n;
        pend.push_back(e);
    endtask

    // The controller returns to IDLE at rel cycle a; from there the line parks at J.
    task automatic finish_at(input int a, input bit s);
        while (ln_q.size() < a + 1) add(LJ, 1'b0);
        while (ln_q.size() > a + 1) begin
            void'(ln_q.pop_back());
            void'(st_q.pop_back());
        end
        ln_q[a] = LJ;
        st_q[a] = s;
        repeat (4) add(LJ, 1'b0);
    endtask

    task automatic play();
        int  base;
        ev_t e;
        @(negedge clk);
        base = cyc + 1;
        foreach (pend[i]) begin
            e     = pend[i];
            e.cyc = base + e.cyc;
            exp_q.push_back(e);
        end
        for (int i = 0; i < ln_q.size(); i++) begin
            if (i > 0) @(negedge clk);
            {dp_sync, dm_sync} = ln_q[i];
            bit_strobe         = st_q[i];
        end
    endtask

    task automatic start_packet();
        int s0;
        ln_q.delete();
        st_q.delete();
        pend.delete();
        g0 = 1 << 30;
        repeat ($urandom_range(3, 20)) add(LJ, $urandom_range(0, 4) == 0);
        s0 = ln_q.size();
        add(LK, $urandom_range(0, 1) == 1);
        g0 = s0 + 1;
        expect_ev(g0, V_SOP, "sop");
    endtask

    task automatic run_packet();
        int n, pct, run, k, gn, z, j, c, kind;
        bit e, aborted;
        logic [1:0] cl, endl;
        start_packet();
        n       = $urandom_range(1, 12);
        pct     = ($urandom_range(0, 4) == 0) ? 0 : 75;
        cl      = LK;
        run     = 0;
        aborted = 1'b0;
        for (int i = 1; i <= n && !aborted; i++) begin
            e = $urandom_range(0, 99) < pct;
            k = $urandom_range(0, 7);
            for (int o = 0; o < 8; o++) begin
                if (e && o == k) cl = (cl == LJ) ? LK : LJ;
                add_auto(cl);
            end
            if (e) begin
                if (k - 4 > 1 || 4 - k > 1) expect_ev(g0 + 8 * (i - 1) + k + 1, V_RA, "readjust");
                run = (k == 7) ? 0 : 1;
            end else begin
                run++;
                if (run == 7) begin
                    expect_ev(g0 + 8 * i, V_ERR, "stuff_error");
                    finish_at(g0 + 8 * i, 1'b1);
                    aborted = 1'b1;
                end
            end
        end
        if (!aborted) begin
            gn = g0 + 8 * n;
            z  = gn + $urandom_range(1, 6);
            while (ln_q.size() < z) add_auto(cl);
            kind = $urandom_range(0, 4);
            if (kind == 4) begin
                add_auto(LSE1);
                expect_ev(z + 1, V_ERR, "se1_active");
                finish_at(z + 1, 1'b0);
            end else if (kind == 3) begin
                while (ln_q.size() < gn + 33) add_auto(LSE0);
                expect_ev(gn + 33, V_ERR, "se0_timeout");
                finish_at(gn + 33, 1'b0);
            end else begin
                c    = (kind == 1) ? $urandom_range(0, 1) : $urandom_range(0, 3);
                j    = (c == 0) ? gn + 7 : gn + 8 * c + $urandom_range(1, 7);
                endl = (kind == 0) ? LJ : (kind == 1) ? LK : LSE1;
                while (ln_q.size() < j) add_auto(LSE0);
                add_auto(endl);
                if (kind == 0 && c >= 2) expect_ev(j + 1, V_EOP, "eop");
                else expect_ev(j + 1, V_ERR, "eop_abort");
                finish_at(j + 1, 1'b0);
            end
        end
        play();
    endtask

    task automatic reset_mid_packet();
        start_packet();
        repeat (3) add(LK, 1'b0);
        play();
        @(posedge clk);
        #1;
        check("active_before_reset", obs, 6'b110000);
        #1 rst = 1'b1;
        #1;
        check("async_reset", obs, 6'b000000);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL pending_at_reset: %0d events left, required 0", exp_q.size());
        end
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            bit_strobe = $urandom_range(0, 1) == 1;
        end
        bit_strobe = 1'b0;
        #1;
        check("no_sop_after_reset", obs, 6'b000000);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_state", obs, 6'b000000);
        rst = 1'b0;
        for (int p = 0; p < 80; p++) begin
            run_packet();
            if (p == 40) reset_mid_packet();
        end
        reset_mid_packet();
        repeat (4) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d events never seen, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
